// File: rtl/debug_ocimem_pkg.sv
// Shared definitions for the OCI memory debug master: FSM states and jdo field map.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package debug_ocimem_pkg;

    localparam int JDO_W        = 38;
    localparam int JDO_RD_BIT   = 35;   // ocimem_a: also start a read at the new address
    localparam int JDO_DATA_MSB = 34;   // ocimem_b: write data field
    localparam int JDO_DATA_LSB = 3;
    localparam int JDO_ADDR_LSB = 4;    // ocimem_a: word address field base bit

    localparam int WAIT_CNT_W   = 16;   // enough for any legal timeout (1..65535)

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } ocimem_state_t;

endpackage

// File: rtl/debug_ocimem_master.sv
// Debug-side Avalon-MM master: turns JTAG ocimem command pulses into single-word bus reads/writes.
// Latency: command pulse to monitor_ready=1 is 2 cycles with no waitrequest, +1 per stalled cycle.
// Backpressure: holds the access stable under avm_waitrequest; aborts after TIMEOUT_CYCLES stalls.
module debug_ocimem_master
    import debug_ocimem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 18
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [JDO_W-1:0]    jdo,
    input  logic                take_action_ocimem_a,
    input  logic                take_no_action_ocimem_a,
    input  logic                take_action_ocimem_b,
    output logic [31:0]         MonDReg,
    output logic                monitor_ready,
    output logic                monitor_error,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [31:0]         avm_writedata,
    output logic [3:0]          avm_byteenable,
    input  logic [31:0]         avm_readdata,
    input  logic                avm_waitrequest
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(TIMEOUT_CYCLES);

    ocimem_state_t           state;
    logic [ADDR_W-3:0]       waddr;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic [WAIT_CNT_W-1:0]   wait_cnt_inc;
    logic                    any_cmd;
    logic [31:0]             jdo_data;
    logic [ADDR_W-3:0]       jdo_waddr;
    logic                    unused_jdo_bits;

    assign jdo_data        = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
    assign jdo_waddr       = jdo[ADDR_W+1:JDO_ADDR_LSB];
    assign unused_jdo_bits = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_DATA_LSB-1:0]};

    assign any_cmd        = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign wait_cnt_inc   = wait_cnt + WAIT_CNT_W'(1);
    assign avm_address    = {waddr, 2'b00};
    assign avm_byteenable = 4'hF;

    // Command acceptance, bus access sequencing, timeout and sticky error tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            waddr         <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            wait_cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Write wins over address load, which wins over a plain read.
                    if (take_action_ocimem_b) begin
                        MonDReg       <= jdo_data;
                        avm_writedata <= jdo_data;
                        avm_write     <= 1'b1;
                        monitor_ready <= 1'b0;
                        monitor_error <= 1'b0;
                        wait_cnt      <= '0;
                        state         <= ST_WR;
                    end else if (take_action_ocimem_a) begin
                        waddr         <= jdo_waddr;
                        monitor_error <= 1'b0;
                        if (jdo[JDO_RD_BIT]) begin
                            avm_read      <= 1'b1;
                            monitor_ready <= 1'b0;
                            wait_cnt      <= '0;
                            state         <= ST_RD;
                        end
                    end else if (take_no_action_ocimem_a) begin
                        avm_read      <= 1'b1;
                        monitor_ready <= 1'b0;
                        monitor_error <= 1'b0;
                        wait_cnt      <= '0;
                        state         <= ST_RD;
                    end
                end

                ST_RD, ST_WR: begin
                    if (any_cmd) begin
                        monitor_error <= 1'b1;
                    end
                    if (!avm_waitrequest) begin
                        if (state == ST_RD) begin
                            MonDReg <= avm_readdata;
                        end
                        waddr         <= waddr + 1'b1;
                        avm_read      <= 1'b0;
                        avm_write     <= 1'b0;
                        monitor_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end else if (wait_cnt_inc == TIMEOUT_VAL) begin
                        // Abandon the access: address and MonDReg are left untouched.
                        avm_read      <= 1'b0;
                        avm_write     <= 1'b0;
                        monitor_ready <= 1'b1;
                        monitor_error <= 1'b1;
                        state         <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt_inc;
                    end
                end

                default: begin
                    avm_read      <= 1'b0;
                    avm_write     <= 1'b0;
                    monitor_ready <= 1'b1;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_ocimem_master.sv
// Directed bench for debug_ocimem_master with a bus-transaction scoreboard.
// Latency: n/a (testbench).
// Backpressure: bench drives avm_waitrequest directly to stall or stick the bus.
module tb_debug_ocimem_master;

    typedef struct packed {
        logic        wr;
        logic [17:0] addr;
        logic [31:0] data;
    } bus_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_no_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic [17:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    int n_cmp = 0;
    int n_err = 0;
    int n_rd_cyc = 0;
    int n_wr_cyc = 0;
    bus_exp_t sb[$];

    always #5 clk = ~clk;

    debug_ocimem_master #(.TIMEOUT_CYCLES(255), .ADDR_W(18)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .avm_address             (avm_address),
        .avm_read                (avm_read),
        .avm_write               (avm_write),
        .avm_writedata           (avm_writedata),
        .avm_byteenable          (avm_byteenable),
        .avm_readdata            (avm_readdata),
        .avm_waitrequest         (avm_waitrequest)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Watches the bus on every falling edge: counts active cycles, checks stability under
    // waitrequest, and matches each completed transfer against the scoreboard.
    task automatic bus_monitor();
        logic        p_act = 1'b0;
        logic        p_wait = 1'b0;
        logic        p_rd = 1'b0;
        logic [17:0] p_addr = '0;
        logic [31:0] p_wdata = '0;
        bus_exp_t    e;
        forever begin
            @(negedge clk);
            if (avm_read)  n_rd_cyc++;
            if (avm_write) n_wr_cyc++;
            if (p_act && p_wait && (avm_read || avm_write)) begin
                check("stable_addr", 64'(avm_address), 64'(p_addr));
                check("stable_rd", 64'(avm_read), 64'(p_rd));
                if (!p_rd) check("stable_wdata", 64'(avm_writedata), 64'(p_wdata));
            end
            if ((avm_read || avm_write) && !avm_waitrequest) begin
                if (sb.size() == 0) begin
                    check("unexpected_xfer", 64'(avm_address), 64'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("xfer_kind", 64'(avm_write), 64'(e.wr));
                    check("xfer_addr", 64'(avm_address), 64'(e.addr));
                    if (e.wr) check("xfer_wdata", 64'(avm_writedata), 64'(e.data));
                end
            end
            p_act   = avm_read || avm_write;
            p_wait  = avm_waitrequest;
            p_rd    = avm_read;
            p_addr  = avm_address;
            p_wdata = avm_writedata;
        end
    endtask

    // which: 0 = ocimem_a, 1 = no_action_ocimem_a, 2 = ocimem_b, 3 = ocimem_a and ocimem_b together
    task automatic send(input int which, input logic [37:0] j);
        @(posedge clk); #1;
        jdo = j;
        take_action_ocimem_a    = (which == 0) || (which == 3);
        take_no_action_ocimem_a = (which == 1);
        take_action_ocimem_b    = (which == 2) || (which == 3);
        @(posedge clk); #1;
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
    endtask

    task automatic wait_ready(input string tag, output int n);
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            n++;
            if (monitor_ready) return;
        end
        check({tag, "_timeout"}, 64'(monitor_ready), 64'd1);
    endtask

    function automatic logic [37:0] jdo_a(input logic rd, input logic [15:0] wa);
        logic [37:0] j;
        j = '0;
        j[35] = rd;
        j[19:4] = wa;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    initial begin
        int n;
        int rd0;
        int wr0;
        logic [37:0] j;

        reset = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        avm_readdata = 32'h0;
        avm_waitrequest = 1'b0;
        fork
            bus_monitor();
        join_none
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(monitor_ready), 64'd1);
        check("rst_error", 64'(monitor_error), 64'd0);
        check("rst_mondreg", 64'(MonDReg), 64'd0);
        check("rst_rw", 64'({avm_read, avm_write}), 64'd0);
        check("rst_addr", 64'(avm_address), 64'd0);
        check("byteenable", 64'(avm_byteenable), 64'hF);

        // Scenario 1: load address 0x0100 with read, no stall.
        avm_readdata = 32'hCAFE_F00D;
        rd0 = n_rd_cyc;
        sb.push_back('{wr: 1'b0, addr: 18'h00400, data: 32'h0});
        send(0, jdo_a(1'b1, 16'h0100));
        @(negedge clk);
        check("s1_busy", 64'(monitor_ready), 64'd0);
        check("s1_read", 64'(avm_read), 64'd1);
        check("s1_addr", 64'(avm_address), 64'h00400);
        @(negedge clk);
        check("s1_ready_2cyc", 64'(monitor_ready), 64'd1);
        check("s1_mondreg", 64'(MonDReg), 64'hCAFE_F00D);
        check("s1_waddr_inc", 64'(avm_address), 64'h00404);
        check("s1_rd_cycles", 64'(n_rd_cyc - rd0), 64'd1);

        // Scenario 2: write 0x12345678 with waitrequest held for 3 cycles.
        avm_waitrequest = 1'b1;
        wr0 = n_wr_cyc;
        sb.push_back('{wr: 1'b1, addr: 18'h00404, data: 32'h1234_5678});
        send(2, jdo_b(32'h1234_5678));
        repeat (3) @(posedge clk);
        #1 avm_waitrequest = 1'b0;
        wait_ready("s2", n);
        check("s2_wr_cycles", 64'(n_wr_cyc - wr0), 64'd4);
        check("s2_waddr_inc", 64'(avm_address), 64'h00408);
        check("s2_error", 64'(monitor_error), 64'd0);
        check("s2_mondreg", 64'(MonDReg), 64'h1234_5678);

        // Scenario 3: read with waitrequest stuck high, aborted by timeout.
        avm_waitrequest = 1'b1;
        avm_readdata = 32'h5555_AAAA;
        rd0 = n_rd_cyc;
        send(1, '0);
        wait_ready("s3", n);
        check("s3_rd_cycles", 64'(n_rd_cyc - rd0), 64'd255);
        check("s3_latency", 64'(n), 64'd256);
        check("s3_error", 64'(monitor_error), 64'd1);
        check("s3_waddr_kept", 64'(avm_address), 64'h00408);
        check("s3_mondreg_kept", 64'(MonDReg), 64'h1234_5678);

        // Scenario 4: stray read command while a write is stalled.
        sb.push_back('{wr: 1'b1, addr: 18'h00408, data: 32'hA5A5_0001});
        send(2, jdo_b(32'hA5A5_0001));
        @(negedge clk);
        check("s4_err_cleared", 64'(monitor_error), 64'd0);
        send(1, '0);
        @(negedge clk);
        check("s4_err_set", 64'(monitor_error), 64'd1);
        check("s4_still_wr", 64'({avm_write, avm_read}), 64'b10);
        @(posedge clk); #1 avm_waitrequest = 1'b0;
        wait_ready("s4", n);
        check("s4_waddr_inc", 64'(avm_address), 64'h0040C);
        check("s4_err_sticky", 64'(monitor_error), 64'd1);
        check("s4_mondreg", 64'(MonDReg), 64'hA5A5_0001);
        rd0 = n_rd_cyc;
        send(0, jdo_a(1'b0, 16'hFFFF));
        @(negedge clk);
        check("s4_err_clear_next", 64'(monitor_error), 64'd0);
        check("s4_addr_only_ready", 64'(monitor_ready), 64'd1);
        check("s4_addr_load", 64'(avm_address), 64'h3FFFC);
        check("s4_no_read", 64'(n_rd_cyc - rd0), 64'd0);

        // Scenario 5: write at the top word wraps the address; coinciding a+b pulses write only.
        sb.push_back('{wr: 1'b1, addr: 18'h3FFFC, data: 32'hDEAD_BEEF});
        send(2, jdo_b(32'hDEAD_BEEF));
        wait_ready("s5a", n);
        check("s5_wrap", 64'(avm_address), 64'h00000);
        j = jdo_b(32'h1357_9BDF);
        j[35] = 1'b1;
        rd0 = n_rd_cyc;
        wr0 = n_wr_cyc;
        sb.push_back('{wr: 1'b1, addr: 18'h00000, data: 32'h1357_9BDF});
        send(3, j);
        wait_ready("s5b", n);
        check("s5_prio_no_read", 64'(n_rd_cyc - rd0), 64'd0);
        check("s5_prio_one_write", 64'(n_wr_cyc - wr0), 64'd1);
        check("s5_prio_addr", 64'(avm_address), 64'h00004);
        check("s5_prio_mondreg", 64'(MonDReg), 64'h1357_9BDF);

        // Scenario 6: reset while a read is stalled.
        avm_waitrequest = 1'b1;
        avm_readdata = 32'h1111_2222;
        send(1, '0);
        @(negedge clk);
        check("s6_in_rd", 64'(avm_read), 64'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("s6_read_dropped", 64'(avm_read), 64'd0);
        check("s6_ready", 64'(monitor_ready), 64'd1);
        check("s6_mondreg", 64'(MonDReg), 64'd0);
        check("s6_waddr", 64'(avm_address), 64'd0);
        avm_waitrequest = 1'b0;
        rd0 = n_rd_cyc;
        repeat (5) @(negedge clk);
        check("s6_no_late_read", 64'(n_rd_cyc - rd0), 64'd0);
        check("s6_mondreg_kept", 64'(MonDReg), 64'd0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/debug_ocimem_master.md
DEBUG_OCIMEM_MASTER -- requirements
Module: debug_ocimem_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the bus-wait cycle count after which an access is aborted (legal 1..65535).
REQ-002 SHALL have parameter ADDR_W, default 18, the byte-address width of the bus master port.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port jdo, input, 38, the JTAG data word captured in the clk domain.
REQ-006 SHALL have port take_action_ocimem_a, input, 1, a one-cycle pulse: load address, with optional read.
REQ-007 SHALL have port take_no_action_ocimem_a, input, 1, a one-cycle pulse: read at the current address.
REQ-008 SHALL have port take_action_ocimem_b, input, 1, a one-cycle pulse: write jdo data at the current address.
REQ-009 SHALL have port MonDReg, output, 32, the monitor data register returned to the debug TCK shifter.
REQ-010 SHALL have port monitor_ready, output, 1, high when idle and the last command is complete.
REQ-011 SHALL have port monitor_error, output, 1, sticky error flag for a timeout or a command received while busy.
REQ-012 SHALL have ports avm_address (output, ADDR_W), avm_read (output, 1), avm_write (output, 1), avm_writedata (output, 32), avm_byteenable (output, 4), avm_readdata (input, 32) and avm_waitrequest (input, 1), forming an Avalon-MM master.

Function
REQ-013 SHALL hold an internal word address register waddr[ADDR_W-3:0]; avm_address SHALL equal {waddr, 2'b00}.
REQ-014 On an accepted take_action_ocimem_a: waddr <= jdo[ADDR_W-1+2:4]; if jdo[35]=1, a read at the new address SHALL start next cycle; otherwise no bus access occurs and monitor_ready stays 1.
REQ-015 On an accepted take_no_action_ocimem_a: a read SHALL start at the current waddr.
REQ-016 On an accepted take_action_ocimem_b: MonDReg <= jdo[34:3] and a write of jdo[34:3] SHALL start at the current waddr.
REQ-017 Priority when pulses coincide: ocimem_b > ocimem_a > no_action_ocimem_a; lower-priority pulses in the same cycle SHALL be discarded silently.
REQ-018 FSM states: IDLE, RD, WR. IDLE->RD or IDLE->WR occurs on the cycle after acceptance. RD/WR->IDLE occurs on the first edge where avm_waitrequest=0, or on timeout.
REQ-019 avm_read=1 only in RD and avm_write=1 only in WR; address, writedata and read/write SHALL stay stable while avm_waitrequest=1.
REQ-020 avm_byteenable SHALL be constant 4'hF.
REQ-021 Read completion: MonDReg <= avm_readdata on the same edge the FSM leaves RD.
REQ-022 Every completed read or write SHALL post-increment waddr by 1, wrapping from all-ones to 0.
REQ-023 Minimum latency from command pulse to monitor_ready=1 SHALL be 2 cycles when waitrequest=0.
REQ-024 monitor_ready SHALL clear on the edge that accepts a command starting a bus access, and set on return to IDLE.
REQ-025 A wait counter SHALL reset on entry to RD/WR and increment each waitrequest=1 cycle; when it reaches TIMEOUT_CYCLES the FSM SHALL go to IDLE with no increment and no MonDReg update, and monitor_error SHALL be set.
REQ-026 Any command pulse arriving in RD/WR SHALL be ignored and SHALL set monitor_error.
REQ-027 monitor_error SHALL clear only when the next command is accepted in IDLE; if that cycle also sets it, set wins.

Reset
REQ-028 Reset SHALL force state IDLE, waddr=0, MonDReg=0, monitor_ready=1, monitor_error=0, avm_read=0, avm_write=0 and wait counter 0 on the next edge, including mid-access; a pending bus response is then dropped.

Structure
REQ-029 The FSM state enum and the jdo field positions (read-enable bit 35, data 34:3, address base bit 4) SHALL live in a shared package debug_ocimem_pkg.
REQ-030 The design SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-031 Scenario 1: ocimem_a with jdo address field 0x0100 and jdo[35]=1, waitrequest=0, readdata=0xCAFEF00D -> avm_read high for 1 cycle at avm_address 0x00400; MonDReg=0xCAFEF00D; waddr=0x0101; ready after 2 cycles.
REQ-032 Scenario 2: ocimem_b with data 0x12345678, waitrequest held 3 cycles -> avm_write high for 4 cycles with stable data; waddr incremented; monitor_error=0.
REQ-033 Scenario 3: read with waitrequest stuck at 1 -> abort after exactly 255 wait cycles; monitor_error=1; waddr and MonDReg unchanged.
REQ-034 Scenario 4: no_action_ocimem_a pulse during a stalled write -> pulse ignored, monitor_error=1; the next accepted command clears it.
REQ-035 Scenario 5: waddr all-ones followed by a write -> waddr wraps to 0. Simultaneous ocimem_a and ocimem_b pulses -> only the write executes.
REQ-036 Scenario 6: reset asserted in the middle of RD -> next edge gives avm_read=0, monitor_ready=1, MonDReg=0.
